// File: rtl/riscv_processor.sv
// riscv_processor: single-cycle RV32I core, CPI=1.
// Harvard ports: combinational ROM fetch, combinational-read data port.
module riscv_processor #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] ProgAddress_o,
  input  logic [31:0]     ProgIn_i,
  output logic [XLEN-1:0] DataAddress_o,
  output logic [XLEN-1:0] DataOut_o,
  input  logic [XLEN-1:0] DataIn_i,
  output logic            we_o
);

  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUI = 7'h17;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_JLR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;

  logic [31:0] pc_q, pc_d, pc_p4;
  logic [31:0] rf_q [32];

  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] alu_b, alu_y, ea, jlr_t, ld_v, wb_d;
  logic [15:0] ld_sh;
  logic        alu_alt, br_take, wb_en_d, is_st;

  assign op    = ProgIn_i[6:0];
  assign rd    = ProgIn_i[11:7];
  assign f3    = ProgIn_i[14:12];
  assign rs1   = ProgIn_i[19:15];
  assign rs2   = ProgIn_i[24:20];
  assign imm_i = {{20{ProgIn_i[31]}}, ProgIn_i[31:20]};
  assign imm_s = {{20{ProgIn_i[31]}}, ProgIn_i[31:25], ProgIn_i[11:7]};
  assign imm_b = {{20{ProgIn_i[31]}}, ProgIn_i[7], ProgIn_i[30:25],
                  ProgIn_i[11:8], 1'b0};
  assign imm_u = {ProgIn_i[31:12], 12'h000};
  assign imm_j = {{12{ProgIn_i[31]}}, ProgIn_i[19:12], ProgIn_i[20],
                  ProgIn_i[30:21], 1'b0};

  assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign pc_p4 = pc_q + 32'd4;
  assign ea    = rs1_v + ((op == OP_ST) ? imm_s : imm_i);
  assign jlr_t = rs1_v + imm_i;

  always_comb begin
    alu_b   = (op == OP_REG) ? rs2_v : imm_i;
    alu_alt = ProgIn_i[30] & ((op == OP_REG) | (f3 == 3'd5));
    alu_y   = '0;
    unique case (f3)
      3'd0: alu_y = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_y = rs1_v << alu_b[4:0];
      3'd2: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_y = {31'b0, rs1_v < alu_b};
      3'd4: alu_y = rs1_v ^ alu_b;
      3'd5: alu_y = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0])
                            : rs1_v >> alu_b[4:0];
      3'd6: alu_y = rs1_v | alu_b;
      3'd7: alu_y = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    unique case (f3)
      3'd0:    br_take = rs1_v == rs2_v;
      3'd1:    br_take = rs1_v != rs2_v;
      3'd4:    br_take = $signed(rs1_v) < $signed(rs2_v);
      3'd5:    br_take = $signed(rs1_v) >= $signed(rs2_v);
      3'd6:    br_take = rs1_v < rs2_v;
      3'd7:    br_take = rs1_v >= rs2_v;
      default: br_take = 1'b0;
    endcase
  end

  // Little-endian lane select before extension.
  assign ld_sh = 16'(DataIn_i >> {ea[1:0], 3'b000});

  always_comb begin
    ld_v = DataIn_i;
    unique case (f3)
      3'd0:    ld_v = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_v = {{16{ld_sh[15]}}, ld_sh};
      3'd4:    ld_v = {24'h0, ld_sh[7:0]};
      3'd5:    ld_v = {16'h0, ld_sh};
      default: ld_v = DataIn_i;
    endcase
  end

  always_comb begin
    pc_d    = pc_p4;
    wb_en_d = 1'b0;
    wb_d    = alu_y;
    is_st   = 1'b0;
    unique case (1'b1)
      op == OP_LUI: begin
        wb_en_d = 1'b1;
        wb_d    = imm_u;
      end
      op == OP_AUI: begin
        wb_en_d = 1'b1;
        wb_d    = pc_q + imm_u;
      end
      op == OP_JAL: begin
        wb_en_d = 1'b1;
        wb_d    = pc_p4;
        pc_d    = pc_q + imm_j;
      end
      op == OP_JLR: begin
        wb_en_d = 1'b1;
        wb_d    = pc_p4;
        pc_d    = {jlr_t[31:1], 1'b0};
      end
      op == OP_BR: begin
        if (br_take) pc_d = pc_q + imm_b;
      end
      op == OP_LD: begin
        wb_en_d = 1'b1;
        wb_d    = ld_v;
      end
      op == OP_ST: is_st = 1'b1;
      op == OP_IMM,
      op == OP_REG: wb_en_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wb_en_d && rd != 5'd0) rf_q[rd] <= wb_d;
    end
  end

  // Data port is forced quiet while reset is asserted.
  assign ProgAddress_o = pc_q;
  assign we_o          = rst_i & is_st;
  assign DataAddress_o = rst_i ? ea : '0;
  assign DataOut_o     = rst_i ? rs2_v : '0;

endmodule

// File: tb/tb_riscv_processor.sv
// tb_riscv_processor: directed programs for the single-cycle core.
// Stores are logged mid-cycle and compared against hand-computed values.
module tb_riscv_processor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ProgAddress_o, ProgIn_i;
  logic [31:0] DataAddress_o, DataOut_o, DataIn_i;
  logic        we_o;

  always #5 clk_i = ~clk_i;

  riscv_processor dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ProgAddress_o(ProgAddress_o),
    .ProgIn_i     (ProgIn_i),
    .DataAddress_o(DataAddress_o),
    .DataOut_o    (DataOut_o),
    .DataIn_i     (DataIn_i),
    .we_o         (we_o)
  );

  logic [31:0] rom [256];
  logic [31:0] ram [1024];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  int          n_run = 0;
  int          n_fail = 0;
  int          wp = 0;

  assign ProgIn_i = rom[ProgAddress_o[9:2]];
  assign DataIn_i = ram[DataAddress_o[11:2]];

  always @(negedge clk_i) begin
    if (rst_i && we_o) begin
      log_a.push_back(DataAddress_o);
      log_d.push_back(DataOut_o);
      ram[DataAddress_o[11:2]] <= DataOut_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int i,
                        input logic [31:0] a, input logic [31:0] d);
    check({tag, ".addr"}, (i < log_a.size()) ? log_a[i] : 32'hx, a);
    check({tag, ".data"}, (i < log_d.size()) ? log_d[i] : 32'hx, d);
  endtask

  function automatic logic [31:0] iw(input logic [31:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] sw_(input logic [31:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(input logic [31:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rr(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] uw(input logic [31:0] imm,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction

  function automatic logic [31:0] jw(input logic [31:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic put(input logic [31:0] w);
    rom[wp] = w;
    wp++;
  endtask

  task automatic restart();
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    wp = 0;
    log_a.delete();
    log_d.delete();
    @(negedge clk_i);
  endtask

  task automatic go(input int n);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  logic [7:0] hola [10] = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h20,
                            8'h6D, 8'h75, 8'h6E, 8'h64, 8'h6F};

  initial begin
    rst_i = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;

    // Reset hold, PC stepping and first store
    restart();
    put(uw(32'h1, 5'd1, 7'h37));
    put(iw(32'h48, 5'd0, 3'd0, 5'd2, 7'h13));
    put(sw_(32'h0, 5'd2, 5'd1, 3'd2));
    repeat (4) @(negedge clk_i);
    #1;
    check("rst.pc", ProgAddress_o, 32'h0);
    check("rst.we", {31'b0, we_o}, 32'h0);
    check("rst.da", DataAddress_o, 32'h0);
    check("rst.do", DataOut_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    #1 check("pc0", ProgAddress_o, 32'h0);
    @(negedge clk_i);
    #1 check("pc4", ProgAddress_o, 32'h4);
    @(negedge clk_i);
    #1 check("pc8", ProgAddress_o, 32'h8);
    check("sw.we", {31'b0, we_o}, 32'h1);
    check("sw.da", DataAddress_o, 32'h1000);
    check("sw.do", DataOut_o, 32'h48);
    #2 rst_i = 1'b0;
    #1;
    check("midrst.we", {31'b0, we_o}, 32'h0);
    check("midrst.pc", ProgAddress_o, 32'h0);
    check("midrst.da", DataAddress_o, 32'h0);
    chk_st("sw.log", 0, 32'h1000, 32'h48);

    // Register file cleared by reset: x2 held 0x48 before
    restart();
    put(sw_(32'h50, 5'd2, 5'd0, 3'd2));
    go(2);
    check("clr.cnt", log_d.size(), 32'd1);
    chk_st("clr", 0, 32'h50, 32'h0);

    // Hola mundo copy loop: lbu from 0x1100+i, sb to 0x1000+i
    restart();
    ram[32'h40] = 32'h616C6F48;
    ram[32'h41] = 32'h6E756D20;
    ram[32'h42] = 32'h00006F64;
    put(uw(32'h1, 5'd1, 7'h37));
    put(iw(32'h100, 5'd1, 3'd0, 5'd2, 7'h13));
    put(iw(32'd10, 5'd0, 3'd0, 5'd3, 7'h13));
    put(iw(32'h0, 5'd2, 3'd4, 5'd4, 7'h03));
    put(sw_(32'h0, 5'd4, 5'd1, 3'd0));
    put(iw(32'h1, 5'd1, 3'd0, 5'd1, 7'h13));
    put(iw(32'h1, 5'd2, 3'd0, 5'd2, 7'h13));
    put(iw(32'hFFFFFFFF, 5'd3, 3'd0, 5'd3, 7'h13));
    put(br(32'hFFFFFFEC, 5'd0, 5'd3, 3'd1));
    put(jw(32'h0, 5'd0));
    go(80);
    check("hola.cnt", log_d.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("hola.addr", (i < log_a.size()) ? log_a[i] : 32'hx,
            32'h1000 + i);
      check("hola.chr", (i < log_d.size()) ? (log_d[i] & 32'hFF) : 32'hx,
            {24'h0, hola[i]});
    end

    // Load lane select and extension
    restart();
    ram[0] = 32'h800000F0;
    put(uw(32'h1, 5'd1, 7'h37));
    put(iw(32'h0, 5'd1, 3'd0, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(iw(32'h0, 5'd1, 3'd4, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(iw(32'h2, 5'd1, 3'd1, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(iw(32'h2, 5'd1, 3'd5, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(iw(32'h3, 5'd1, 3'd2, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(iw(32'h1, 5'd1, 3'd0, 5'd3, 7'h03));
    put(sw_(32'h4, 5'd3, 5'd1, 3'd2));
    put(jw(32'h0, 5'd0));
    go(20);
    check("ld.cnt", log_d.size(), 32'd6);
    chk_st("lb", 0, 32'h1004, 32'hFFFFFFF0);
    chk_st("lbu", 1, 32'h1004, 32'h000000F0);
    chk_st("lh", 2, 32'h1004, 32'hFFFF8000);
    chk_st("lhu", 3, 32'h1004, 32'h00008000);
    chk_st("lw", 4, 32'h1004, 32'h800000F0);
    chk_st("lb1", 5, 32'h1004, 32'h00000000);

    // Branches, JAL and JALR
    restart();
    put(iw(32'hFFFFFFFF, 5'd0, 3'd0, 5'd1, 7'h13));
    put(iw(32'h1, 5'd0, 3'd0, 5'd2, 7'h13));
    put(br(32'h8, 5'd2, 5'd1, 3'd4));
    put(sw_(32'h10, 5'd0, 5'd0, 3'd2));
    put(br(32'h8, 5'd2, 5'd1, 3'd6));
    put(sw_(32'h14, 5'd2, 5'd0, 3'd2));
    put(32'h00000013);
    put(32'h00000013);
    put(jw(32'h8, 5'd5));
    put(jw(32'hC, 5'd0));
    put(sw_(32'h18, 5'd5, 5'd0, 3'd2));
    put(iw(32'h0, 5'd5, 3'd0, 5'd0, 7'h67));
    put(br(32'h8, 5'd2, 5'd1, 3'd5));
    put(br(32'h8, 5'd2, 5'd1, 3'd7));
    put(sw_(32'h1C, 5'd0, 5'd0, 3'd2));
    put(br(32'h8, 5'd1, 5'd1, 3'd0));
    put(sw_(32'h20, 5'd0, 5'd0, 3'd2));
    put(sw_(32'h24, 5'd1, 5'd0, 3'd2));
    put(jw(32'h0, 5'd0));
    go(40);
    check("br.cnt", log_d.size(), 32'd3);
    chk_st("bltu.nt", 0, 32'h14, 32'h1);
    chk_st("jal.link", 1, 32'h18, 32'h24);
    chk_st("beq.t", 2, 32'h24, 32'hFFFFFFFF);
    check("br.endpc", ProgAddress_o, 32'h48);

    // x0, NOP-class opcodes and ALU ops
    restart();
    put(iw(32'h5, 5'd0, 3'd0, 5'd0, 7'h13));
    put(rr(7'h00, 5'd0, 5'd0, 3'd0, 5'd4));
    put(32'h00001273);
    put(sw_(32'h40, 5'd4, 5'd0, 3'd2));
    put(32'h0000007F);
    put(32'h00000073);
    put(iw(32'hFFFFFFF0, 5'd0, 3'd0, 5'd6, 7'h13));
    put(iw(32'h402, 5'd6, 3'd5, 5'd7, 7'h13));
    put(sw_(32'h44, 5'd7, 5'd0, 3'd2));
    put(iw(32'd28, 5'd6, 3'd5, 5'd7, 7'h13));
    put(sw_(32'h48, 5'd7, 5'd0, 3'd2));
    put(rr(7'h20, 5'd6, 5'd0, 3'd0, 5'd8));
    put(rr(7'h00, 5'd8, 5'd8, 3'd1, 5'd9));
    put(sw_(32'h4C, 5'd9, 5'd0, 3'd2));
    put(rr(7'h00, 5'd8, 5'd6, 3'd2, 5'd10));
    put(sw_(32'h50, 5'd10, 5'd0, 3'd2));
    put(rr(7'h00, 5'd8, 5'd6, 3'd3, 5'd10));
    put(sw_(32'h54, 5'd10, 5'd0, 3'd2));
    put(uw(32'h1, 5'd11, 7'h17));
    put(sw_(32'h58, 5'd11, 5'd0, 3'd2));
    put(iw(32'hFF, 5'd6, 3'd4, 5'd12, 7'h13));
    put(sw_(32'h5C, 5'd12, 5'd0, 3'd2));
    put(jw(32'h0, 5'd0));
    go(30);
    check("alu.cnt", log_d.size(), 32'd8);
    chk_st("x0", 0, 32'h40, 32'h0);
    chk_st("srai", 1, 32'h44, 32'hFFFFFFFC);
    chk_st("srli", 2, 32'h48, 32'h0000000F);
    chk_st("sll", 3, 32'h4C, 32'h00100000);
    chk_st("slt", 4, 32'h50, 32'h1);
    chk_st("sltu", 5, 32'h54, 32'h0);
    chk_st("auipc", 6, 32'h58, 32'h00001048);
    chk_st("xori", 7, 32'h5C, 32'hFFFFFF0F);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
